// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU datapath and an auxiliary
// master. Fixed CPU priority, with aux promoted after MAX_WAIT lost conflicts.
module dmem_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int MEM_LAT  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_gnt,
  output logic              aux_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
      $error("dmem_arbiter: MEM_LAT must be in 1..15");
    end
    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
      $error("dmem_arbiter: MAX_WAIT must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          lat_cnt_q, lat_cnt_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic                owner_q, owner_d;   // 0 = CPU, 1 = aux
  logic                we_q, we_d;
  logic                first_q, first_d;   // marks the first ACCESS cycle
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                grant_aux;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      wait_cnt_q <= '0;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      first_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      first_q    <= first_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    wait_cnt_d = wait_cnt_q;
    owner_d    = owner_q;
    we_d       = we_q;
    first_d    = first_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    grant_aux  = aux_req && (!cpu_req || (wait_cnt_q == WAIT_MAX));
    case (state_q)
      IDLE: begin
        if (cpu_req || aux_req) begin
          state_d   = ACCESS;
          owner_d   = grant_aux;
          we_d      = grant_aux ? aux_we    : cpu_we;
          addr_d    = grant_aux ? aux_addr  : cpu_addr;
          wdata_d   = grant_aux ? aux_wdata : cpu_wdata;
          lat_cnt_d = LAT_INIT;
          first_d   = 1'b1;
        end
        // Aging only accumulates while aux keeps asking and keeps losing.
        if (!aux_req || grant_aux) begin
          wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ACCESS: begin
        first_d = 1'b0;
        if (lat_cnt_q == 4'd0) begin
          state_d = RESP;
          if (!we_q) rdata_d = mem_rdata;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output decodes registered state, so rst clears them asynchronously.
  assign busy      = (state_q != IDLE);
  assign cpu_gnt   = (state_q == ACCESS) && first_q && !owner_q;
  assign aux_gnt   = (state_q == ACCESS) && first_q &&  owner_q;
  assign cpu_done  = (state_q == RESP) && !owner_q;
  assign aux_done  = (state_q == RESP) &&  owner_q;
  assign mem_wr    = (state_q == ACCESS) && first_q && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: memory model, request drivers, completion scoreboard.
module tb_dmem_arbiter;

  localparam int MEM_LAT  = 3;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [63:0] cpu_addr = '0, cpu_wdata = '0;
  logic        aux_req = 1'b0, aux_we = 1'b0;
  logic [63:0] aux_addr = '0, aux_wdata = '0;
  logic        cpu_gnt, cpu_done, aux_gnt, aux_done, mem_wr, busy;
  logic [63:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic [63:0] tb_mem [16];
  logic [64:0] exp_q [$];   // {owner_is_aux, expected rdata at done}
  logic [63:0] last_rdata = '0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  logic [63:0] wr_addr_seen = '0, wr_data_seen = '0;

  dmem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(MEM_LAT), .MAX_WAIT(MAX_WAIT)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_gnt(aux_gnt), .aux_done(aux_done),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // clock / memory model
  always #5 clk = ~clk;

  assign mem_rdata = tb_mem[mem_addr[6:3]];

  always @(posedge clk) begin
    if (mem_wr) tb_mem[mem_addr[6:3]] = mem_wdata;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard / protocol monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_wr) begin
        wr_cnt++;
        wr_addr_seen = mem_addr;
        wr_data_seen = mem_wdata;
      end
      if (cpu_gnt || aux_gnt || cpu_done || aux_done) begin
        check("one_gnt", 64'(cpu_gnt & aux_gnt), 0);
        check("one_done", 64'(cpu_done & aux_done), 0);
        check("cpu_gnt_done", 64'(cpu_gnt & cpu_done), 0);
        check("aux_gnt_done", 64'(aux_gnt & aux_done), 0);
      end
      if (cpu_done || aux_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          check("done_owner", 64'(aux_done), 64'(e[64]));
          check("done_rdata", rdata, e[63:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic push_exp(input bit is_aux, input bit we, input logic [63:0] addr);
    logic [63:0] d;
    d = we ? last_rdata : tb_mem[addr[6:3]];
    if (!we) last_rdata = d;
    exp_q.push_back({is_aux, d});
  endtask

  task automatic single_req(input bit is_aux, input bit we, input logic [63:0] addr,
                            input logic [63:0] wdata, input string tag);
    int n;
    @(negedge clk);
    push_exp(is_aux, we, addr);
    if (is_aux) begin
      aux_we = we; aux_addr = addr; aux_wdata = wdata; aux_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
    end
    @(negedge clk);
    check({tag, "_gnt"}, 64'(is_aux ? aux_gnt : cpu_gnt), 1);
    check({tag, "_other_gnt"}, 64'(is_aux ? cpu_gnt : aux_gnt), 0);
    check({tag, "_busy"}, 64'(busy), 1);
    cpu_req = 1'b0;
    aux_req = 1'b0;
    n = 1;
    while (!(is_aux ? aux_done : cpu_done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_lat"}, 64'(n), 64'(MEM_LAT + 1));
    @(negedge clk);
    check({tag, "_busy_after"}, 64'(busy), 0);
  endtask

  task automatic wait_gnt(output bit owner, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cpu_gnt || aux_gnt) && n < 50);
    if (!(cpu_gnt || aux_gnt)) check({tag, "_gnt_timeout"}, 0, 1);
    owner = aux_gnt;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, 64'(exp_q.size() == 0 && !busy), 1);
    @(negedge clk);
  endtask

  // conflict run: owners[k] is the expected winner of grant k (bit 1 = aux)
  task automatic conflict_run(input logic [15:0] owners, input int count,
                              input int drop_aux_at, input int raise_aux_at, input string tag);
    bit o;
    for (int k = 0; k < count; k++) push_exp(owners[k], 1'b0, owners[k] ? 64'h18 : 64'h10);
    @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 64'h10; cpu_req = 1'b1;
    aux_we = 1'b0; aux_addr = 64'h18; aux_req = 1'b1;
    for (int k = 0; k < count; k++) begin
      wait_gnt(o, tag);
      check($sformatf("%s_order%0d", tag, k), 64'(o), 64'(owners[k]));
      if (k == drop_aux_at)  aux_req = 1'b0;
      if (k == raise_aux_at) aux_req = 1'b1;
      if (k == count - 1) begin
        cpu_req = 1'b0;
        aux_req = 1'b0;
      end
    end
    drain(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    bit o;
    int n, idle;
    for (int i = 0; i < 16; i++) tb_mem[i] = 64'h1111_0000_0000_0000 + 64'(i) * 64'h0101;
    tb_mem[2] = 64'hDEAD_BEEF;

    // reset state
    #12;
    check("rst_busy", 64'(busy), 0);
    check("rst_gnts", 64'({cpu_gnt, aux_gnt, cpu_done, aux_done, mem_wr}), 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // CPU read, then CPU write with rdata held
    single_req(1'b0, 1'b0, 64'h10, 64'h0, "cpu_rd");
    wr_cnt = 0;
    single_req(1'b0, 1'b1, 64'h20, 64'h55, "cpu_wr");
    check("wr_pulses", 64'(wr_cnt), 1);
    check("wr_addr", wr_addr_seen, 64'h20);
    check("wr_data", wr_data_seen, 64'h55);
    check("wr_rdata_held", rdata, 64'hDEAD_BEEF);
    check("idle_mem_addr", mem_addr, 64'h20);
    drain("single");

    // aux back-to-back reads
    push_exp(1'b1, 1'b0, 64'h0);
    push_exp(1'b1, 1'b0, 64'h8);
    @(negedge clk);
    aux_we = 1'b0; aux_addr = 64'h0; aux_req = 1'b1;
    wait_gnt(o, "b2b_first");
    check("b2b_first_owner", 64'(o), 1);
    aux_addr = 64'h8;
    n = 0; idle = 0;
    do begin
      @(negedge clk);
      n++;
      if (!busy) idle++;
    end while (!aux_gnt && n < 50);
    aux_req = 1'b0;
    check("b2b_gnt_sep", 64'(n), 64'(MEM_LAT + 2));
    check("b2b_idle_cycles", 64'(idle), 1);
    drain("b2b");

    // sustained conflict: aux wins once every MAX_WAIT+1 grants
    conflict_run(16'b10_0001_0000, 10, -1, -1, "starve");

    // aux drops mid-run: aging restarts, CPU keeps priority for MAX_WAIT more conflicts
    conflict_run(16'b1_0000_0000, 9, 2, 3, "aux_drop");

    // reset in the second ACCESS cycle of a write
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = 64'h28; cpu_wdata = 64'hAA; cpu_req = 1'b1;
    @(negedge clk);
    check("abort_gnt", 64'(cpu_gnt), 1);
    @(negedge clk);
    cpu_req = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 0);
    check("abort_outs", 64'({cpu_gnt, aux_gnt, cpu_done, aux_done, mem_wr}), 0);
    check("abort_rdata", rdata, 0);
    last_rdata = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) @(negedge clk);
    check("abort_no_busy", 64'(busy), 0);
    single_req(1'b0, 1'b0, 64'h10, 64'h0, "post_rst");
    single_req(1'b1, 1'b0, 64'h30, 64'h0, "post_rst_aux");
    drain("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
